// File: rtl/exec_sequencer.sv
// exec_sequencer: three-state IDLE/DRIVE/DONE sequencer for one instruction.
// It accepts one decoded instruction and drives the ALU operands and control
// code from registers. It then captures the ALU result, works out the branch
// outcome and holds the completion until the consumer takes it.
module exec_sequencer #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [2:0]         in_funct,
    input  logic [WIDTH-1:0]   in_rs_val,
    input  logic [WIDTH-1:0]   in_rt_val,
    input  logic [IMM_W-1:0]   in_imm,
    output logic [WIDTH-1:0]   alu_src1,
    output logic [WIDTH-1:0]   alu_src2,
    output logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_wb,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_taken,
    output logic               out_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_BEQ   = 4'h2;
    localparam logic [3:0] OP_BNE   = 4'h3;
    localparam logic [3:0] OP_LW    = 4'h4;
    localparam logic [3:0] OP_SW    = 4'h5;

    localparam logic [3:0] CTRL_NONE = 4'b0000;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;

    // Widen the immediate by copying its top bit into the upper bits.
    function automatic logic signed [WIDTH-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  src1_q, src1_d;
    logic [WIDTH-1:0]  src2_q, src2_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              wb_q, wb_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic              beq_q, beq_d;
    logic              bne_q, bne_d;

    // Decoded view of the instruction currently offered on the in_* bus.
    logic [WIDTH-1:0]  dec_src1;
    logic [WIDTH-1:0]  dec_src2;
    logic [3:0]        dec_ctrl;
    logic              dec_wb;
    logic              dec_rd;
    logic              dec_wr;
    logic              dec_beq;
    logic              dec_bne;
    logic              dec_ill;

    // Decode the offered opcode/funct into operands, ALU code and side-effect flags.
    always_comb begin
        dec_src1 = '0;
        dec_src2 = '0;
        dec_ctrl = CTRL_NONE;
        dec_wb   = 1'b0;
        dec_rd   = 1'b0;
        dec_wr   = 1'b0;
        dec_beq  = 1'b0;
        dec_bne  = 1'b0;
        dec_ill  = 1'b0;
        unique case (in_opcode)
            OP_RTYPE: begin
                unique case (in_funct)
                    3'b000:  dec_ctrl = CTRL_ADD;
                    3'b001:  dec_ctrl = CTRL_SUB;
                    3'b010:  dec_ctrl = CTRL_SLT;
                    default: dec_ill  = 1'b1;
                endcase
                if (!dec_ill) begin
                    dec_src1 = in_rs_val;
                    dec_src2 = in_rt_val;
                    dec_wb   = 1'b1;
                end
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec_ctrl = CTRL_ADD;
                dec_src1 = in_rs_val;
                dec_src2 = sext_imm(in_imm);
                dec_wb   = (in_opcode == OP_ADDI);
                dec_rd   = (in_opcode == OP_LW);
                dec_wr   = (in_opcode == OP_SW);
            end
            OP_BEQ, OP_BNE: begin
                dec_ctrl = CTRL_SUB;
                dec_src1 = in_rs_val;
                dec_src2 = in_rt_val;
                dec_beq  = (in_opcode == OP_BEQ);
                dec_bne  = (in_opcode == OP_BNE);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Next-state logic: load on accept, capture the ALU result leaving DRIVE, release on handshake.
    always_comb begin
        state_d   = state_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        wb_d      = wb_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        beq_d     = beq_q;
        bne_d     = bne_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = DRIVE;
                    src1_d    = dec_src1;
                    src2_d    = dec_src2;
                    ctrl_d    = dec_ctrl;
                    wb_d      = dec_wb;
                    mem_rd_d  = dec_rd;
                    mem_wr_d  = dec_wr;
                    illegal_d = dec_ill;
                    beq_d     = dec_beq;
                    bne_d     = dec_bne;
                    taken_d   = 1'b0;
                end
            end
            DRIVE: begin
                state_d = DONE;
                // An illegal instruction never reports a result or branch,
                // whatever the ALU happens to show.
                if (illegal_q) begin
                    result_d = '0;
                    taken_d  = 1'b0;
                end else begin
                    result_d = alu_result;
                    taken_d  = (beq_q & alu_zero) | (bne_q & ~alu_zero);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= CTRL_NONE;
            result_q  <= '0;
            wb_q      <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            beq_q     <= 1'b0;
            bne_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            wb_q      <= wb_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            beq_q     <= beq_d;
            bne_q     <= bne_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign alu_ctrl    = ctrl_q;
    assign out_result  = result_q;
    assign out_wb      = wb_q;
    assign out_mem_rd  = mem_rd_q;
    assign out_mem_wr  = mem_wr_q;
    assign out_taken   = taken_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer: directed cases, then randomized instructions
// checked against an arithmetic reference model.
module tb_exec_sequencer;

    localparam int WIDTH = 16;
    localparam int IMM_W = 6;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [2:0]        in_funct;
    logic [WIDTH-1:0]  in_rs_val;
    logic [WIDTH-1:0]  in_rt_val;
    logic [IMM_W-1:0]  in_imm;
    logic [WIDTH-1:0]  alu_src1;
    logic [WIDTH-1:0]  alu_src2;
    logic [3:0]        alu_ctrl;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic              out_wb;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              out_taken;
    logic              out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    exec_sequencer #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_wb(out_wb),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_taken(out_taken), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU; unknown codes return a nonzero junk value with the
    // zero flag raised, so a missing illegal-instruction override shows up.
    always_comb begin
        alu_result = 16'hBEEF;
        alu_zero   = 1'b1;
        case (alu_ctrl)
            4'b0010: begin alu_result = alu_src1 + alu_src2; alu_zero = (alu_result == '0); end
            4'b0110: begin alu_result = alu_src1 - alu_src2; alu_zero = (alu_result == '0); end
            4'b0111: begin
                alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 16'd1 : 16'd0;
                alu_zero   = (alu_result == '0);
            end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [15:0] s1;
        logic [15:0] s2;
        logic [3:0]  ctrl;
        logic [15:0] res;
        logic        wb;
        logic        rd;
        logic        wr;
        logic        tk;
        logic        ill;
    } exp_t;

    // Reference: what each instruction should produce, in plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [2:0] fn,
                                   input logic [15:0] rs, input logic [15:0] rt,
                                   input logic [5:0] imm);
        exp_t e;
        int   immv;
        int   a;
        int   b;
        int   sa;
        int   sb;
        e    = '0;
        immv = int'(imm);
        if (immv >= 32) immv = immv - 64;
        a  = int'(rs);
        b  = int'(rt);
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        if (op == 4'h0 && fn == 3'd0) begin
            e.s1 = rs; e.s2 = rt; e.ctrl = 4'b0010; e.res = 16'(a + b); e.wb = 1'b1;
        end else if (op == 4'h0 && fn == 3'd1) begin
            e.s1 = rs; e.s2 = rt; e.ctrl = 4'b0110; e.res = 16'(a - b); e.wb = 1'b1;
        end else if (op == 4'h0 && fn == 3'd2) begin
            e.s1 = rs; e.s2 = rt; e.ctrl = 4'b0111; e.res = (sa < sb) ? 16'd1 : 16'd0; e.wb = 1'b1;
        end else if (op == 4'h1 || op == 4'h4 || op == 4'h5) begin
            e.s1 = rs; e.s2 = 16'(immv); e.ctrl = 4'b0010; e.res = 16'(a + immv);
            e.wb = (op == 4'h1); e.rd = (op == 4'h4); e.wr = (op == 4'h5);
        end else if (op == 4'h2 || op == 4'h3) begin
            e.s1 = rs; e.s2 = rt; e.ctrl = 4'b0110; e.res = 16'(a - b);
            e.tk = (op == 4'h2) ? (a == b) : (a != b);
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; return just after the falling edge to sample/drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scramble_inputs();
        in_valid  = 1'($urandom);
        in_opcode = 4'($urandom);
        in_funct  = 3'($urandom);
        in_rs_val = 16'($urandom);
        in_rt_val = 16'($urandom);
        in_imm    = 6'($urandom);
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".result"},  32'(out_result),  32'(e.res));
        check({tag, ".wb"},      32'(out_wb),      32'(e.wb));
        check({tag, ".mem_rd"},  32'(out_mem_rd),  32'(e.rd));
        check({tag, ".mem_wr"},  32'(out_mem_wr),  32'(e.wr));
        check({tag, ".taken"},   32'(out_taken),   32'(e.tk));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(e.ill));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".src1"},  32'(alu_src1),  0);
        check({tag, ".src2"},  32'(alu_src2),  0);
        check({tag, ".ctrl"},  32'(alu_ctrl),  0);
        check({tag, ".valid"}, 32'(out_valid), 0);
        check_outs(tag, '0);
    endtask

    // Offer one instruction, follow it through DRIVE and DONE, hold DONE for
    // 'hold' stalled cycles, then complete the handshake.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] fn,
                             input logic [15:0] rs, input logic [15:0] rt,
                             input logic [5:0] imm, input int hold);
        exp_t e;
        int   guard;
        e     = model(op, fn, rs, rt, imm);
        guard = 0;
        while (!in_ready && guard < 20) begin
            in_valid = 1'b0;
            tick();
            guard++;
        end
        check({tag, ".ready"}, 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_funct  = fn;
        in_rs_val = rs;
        in_rt_val = rt;
        in_imm    = imm;
        out_ready = 1'b0;
        tick();
        // DRIVE: operands visible, no handshakes offered; inputs now ignored.
        check({tag, ".drv_ready"}, 32'(in_ready),  0);
        check({tag, ".drv_valid"}, 32'(out_valid), 0);
        check({tag, ".src1"},      32'(alu_src1),  32'(e.s1));
        check({tag, ".src2"},      32'(alu_src2),  32'(e.s2));
        check({tag, ".ctrl"},      32'(alu_ctrl),  32'(e.ctrl));
        scramble_inputs();
        out_ready = 1'($urandom);
        tick();
        check({tag, ".valid"}, 32'(out_valid), 1);
        check_outs(tag, e);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            tick();
            check({tag, ".stall_valid"}, 32'(out_valid), 1);
            check({tag, ".stall_ready"}, 32'(in_ready),  0);
            check({tag, ".stall_src1"},  32'(alu_src1),  32'(e.s1));
            check({tag, ".stall_src2"},  32'(alu_src2),  32'(e.s2));
            check({tag, ".stall_ctrl"},  32'(alu_ctrl),  32'(e.ctrl));
            check_outs({tag, ".stall"}, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, ".rel_valid"}, 32'(out_valid), 0);
        check({tag, ".rel_ready"}, 32'(in_ready),  1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        logic [15:0] rs;
        logic [15:0] rt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opcode = '0;
        in_funct  = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        in_imm    = '0;
        tick();
        tick();
        check("reset.ready", 32'(in_ready), 1);
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check("post_reset.ready", 32'(in_ready), 1);

        run_instr("add",     4'h0, 3'b000, 16'h0005, 16'h0003, 6'd0,      0);
        check("add.known_result", 32'(out_result), 32'h0008);
        run_instr("addi",    4'h1, 3'b000, 16'h0010, 16'h0000, 6'b111110, 0);
        check("addi.known_result", 32'(out_result), 32'h000E);
        run_instr("beq",     4'h2, 3'b000, 16'h1234, 16'h1234, 6'd0,      0);
        check("beq.known_taken", 32'(out_taken), 1);
        run_instr("bne",     4'h3, 3'b000, 16'h1234, 16'h1234, 6'd0,      0);
        check("bne.known_taken", 32'(out_taken), 0);
        run_instr("slt",     4'h0, 3'b010, 16'h0002, 16'h0007, 6'd0,      0);
        check("slt.known_result", 32'(out_result), 32'h0001);
        run_instr("backpr",  4'h0, 3'b001, 16'h0100, 16'h0001, 6'd0,      5);
        run_instr("illegal", 4'hF, 3'b000, 16'hAAAA, 16'h5555, 6'd7,      1);
        run_instr("ill_fn",  4'h0, 3'b011, 16'h0001, 16'h0001, 6'd0,      0);
        run_instr("lw",      4'h4, 3'b000, 16'h0100, 16'h0000, 6'b100000, 0);
        run_instr("sw",      4'h5, 3'b000, 16'h0200, 16'h0000, 6'b011111, 0);

        // Reset while an instruction sits in DRIVE: it must vanish.
        in_valid  = 1'b1;
        in_opcode = 4'h0;
        in_funct  = 3'b000;
        in_rs_val = 16'h0011;
        in_rt_val = 16'h0022;
        tick();
        check("rst_drv.in_drive", 32'(in_ready), 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        out_ready = 1'b1;
        tick();
        check_zero("rst_drv");
        check("rst_drv.ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_drv.no_valid", 32'(out_valid), 0);
            check("rst_drv.idle",     32'(in_ready),  1);
        end

        // Randomized instruction mix, biased toward legal opcodes.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 8))
                0, 1:    op = 4'h0;
                2:       op = 4'h1;
                3:       op = 4'h2;
                4:       op = 4'h3;
                5:       op = 4'h4;
                6:       op = 4'h5;
                default: op = 4'($urandom);
            endcase
            rs = 16'($urandom);
            rt = ($urandom_range(0, 1) == 1) ? rs : 16'($urandom);
            run_instr("rand", op, 3'($urandom_range(0, 4)), rs, rt, 6'($urandom),
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width of operands, result and ALU bus.
REQ-002 SHALL have parameter IMM_W, default 6, width of the instruction immediate field.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  sequencer can accept
- in_opcode  in  4  operation class
- in_funct  in  3  R-type function
- in_rs_val  in  WIDTH  first register operand
- in_rt_val  in  WIDTH  second register operand
- in_imm  in  IMM_W  signed immediate
- alu_src1  out  WIDTH  ALU operand 1
- alu_src2  out  WIDTH  ALU operand 2
- alu_ctrl  out  4  ALU control code
- alu_result  in  WIDTH  ALU combinational result
- alu_zero  in  1  ALU result-is-zero flag
- out_valid  out  1  completed instruction available
- out_ready  in  1  consumer accepts completion
- out_result  out  WIDTH  captured ALU result (write-back value or memory address)
- out_wb  out  1  register write-back required
- out_mem_rd / out_mem_wr  out  1 each  load / store
- out_taken  out  1  branch taken
- out_illegal  out  1  unsupported opcode/funct

Function
REQ-004 SHALL implement FSM states IDLE, DRIVE, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-005 SHALL accept an instruction at a rising edge where in_valid & in_ready; IDLE -> DRIVE; all in_* fields registered at that edge.
REQ-006 SHALL drive alu_src1, alu_src2, alu_ctrl from registers loaded at the accept edge; held stable until the next accept.
REQ-007 SHALL decode: opcode 0x0 R-type, funct 000 add (ctrl 0010), 001 sub (0110), 010 slt (0111), src1=rs, src2=rt, wb=1.
REQ-008 SHALL decode: 0x1 addi, 0x4 lw, 0x5 sw -> ctrl 0010, src1=rs, src2=sign-extended imm; addi wb=1; lw mem_rd=1; sw mem_wr=1.
REQ-009 SHALL decode: 0x2 beq, 0x3 bne -> ctrl 0110, src1=rs, src2=rt; no wb/mem.
REQ-010 SHALL treat any other opcode, or R-type funct 011-111, as illegal: ctrl 0000, src1=src2=0, all side-effect flags 0, illegal=1.
REQ-011 SHALL sign-extend in_imm by replicating bit IMM_W-1 to WIDTH bits.
REQ-012 SHALL, at the edge leaving DRIVE, capture alu_result into out_result and evaluate out_taken = alu_zero for beq, ~alu_zero for bne, 0 otherwise; DRIVE -> DONE unconditionally.
REQ-013 SHALL force out_result = 0 and out_taken = 0 for illegal instructions regardless of ALU inputs.
REQ-014 SHALL hold all out_* stable in DONE until out_valid & out_ready; on that edge DONE -> IDLE, out_valid = 0.
REQ-015 SHALL have latency: out_valid high exactly one cycle after the accept edge; minimum throughput one instruction per 3 cycles; no overlap of instructions.
REQ-016 SHALL ignore in_valid and all in_* changes outside IDLE; SHALL ignore out_ready outside DONE.
REQ-017 SHALL keep out_wb, out_mem_rd, out_mem_wr, out_taken, out_illegal mutually consistent with REQ-007..010 (at most one of wb/mem_rd/mem_wr set).

Reset
REQ-018 SHALL, when rst_n = 0 at a rising edge, enter IDLE and clear alu_src1, alu_src2, alu_ctrl, out_result and all out flags to 0, regardless of current state.
REQ-019 SHALL discard any in-flight instruction on reset mid-DRIVE or mid-DONE; no completion is produced for it.
REQ-020 SHALL present in_ready = 1 in the first cycle after rst_n returns high.

Verification
REQ-021 add: rs=0x0005, rt=0x0003, funct 000 -> alu_ctrl 0010, out_result 0x0008, out_wb 1, out_valid one cycle after accept.
REQ-022 addi sign-extension: rs=0x0010, imm=6'b111110 -> alu_src2 0xFFFE, out_result 0x000E, wb 1.
REQ-023 beq/bne: rs=rt=0x1234 -> beq taken 1; bne same operands -> taken 0; slt rs=0x0002, rt=0x0007 -> result 0x0001.
REQ-024 backpressure: out_ready held 0 for 5 cycles -> out_valid and out_* stable, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-025 illegal: opcode 0xF -> alu_ctrl 0000, out_illegal 1, out_result 0, all other flags 0.
REQ-026 reset in DRIVE: rst_n low one edge -> IDLE, all outputs 0, no out_valid pulse for the dropped instruction.
